// File: rtl/dl11_pkg.sv
// Shared definitions for the DL11 console register block:
// register offsets, bit positions, vectors and TX state encoding.
package dl11_pkg;

    localparam logic [1:0] REG_RCSR = 2'd0;
    localparam logic [1:0] REG_RBUF = 2'd1;
    localparam logic [1:0] REG_XCSR = 2'd2;
    localparam logic [1:0] REG_XBUF = 2'd3;

    localparam int BIT_DONE = 7;
    localparam int BIT_IE   = 6;
    localparam int BIT_ERR  = 15;
    localparam int BIT_OVR  = 14;

    localparam logic [7:0] RX_VEC = 8'o60;
    localparam logic [7:0] TX_VEC = 8'o64;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_WAITB,
        TX_BUSY
    } tx_state_t;

endpackage

// File: rtl/dl11_rx_fifo.sv
// Receive byte FIFO; pointers carry one extra wrap bit so
// full and empty fall out of a plain pointer comparison.
module dl11_rx_fifo
    import dl11_pkg::*;
#(
    parameter int RXDEPTH = 8,
    parameter int RXAW    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    logic [7:0]    r_mem [RXDEPTH];
    logic [RXAW:0] r_wr;
    logic [RXAW:0] r_rd;
    logic          w_push;
    logic          w_pop;

    assign empty = (r_wr == r_rd);
    assign full  = (r_wr[RXAW] != r_rd[RXAW]) &&
                   (r_wr[RXAW-1:0] == r_rd[RXAW-1:0]);
    assign head  = r_mem[r_rd[RXAW-1:0]];

    // A pop on the same edge frees the slot a full push writes into.
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr[RXAW-1:0]] <= din;
    end

endmodule

// File: rtl/dl11_console.sv
// DL11-style console registers: RX FIFO intake, TX handshake FSM
// and separate latched receive/transmit interrupt requests.
module dl11_console
    import dl11_pkg::*;
#(
    parameter int RXDEPTH = 8,
    parameter int RXAW    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic [1:0]  adr,
    input  logic        rd,
    input  logic        we,
    input  logic [15:0] din,
    output logic [15:0] dout,
    input  logic [7:0]  rx_byte,
    input  logic        rx_ready,
    output logic        rx_read,
    output logic [7:0]  tx_byte,
    output logic        tx_send,
    input  logic        tx_busy,
    output logic        rx_irq,
    output logic        tx_irq,
    input  logic        rx_iak,
    input  logic        tx_iak
);

    tx_state_t   r_state;
    tx_state_t   w_state_nxt;
    logic [15:0] r_dout;
    logic [7:0]  r_tx_byte;
    logic        r_rx_read;
    logic        r_tx_send;
    logic        r_rie;
    logic        r_xie;
    logic        r_ovr;
    logic        r_rx_cond;
    logic        r_tx_cond;
    logic        r_rx_irq;
    logic        r_tx_irq;

    logic        w_rd;
    logic        w_wr;
    logic        w_intake;
    logic        w_pop;
    logic        w_push;
    logic        w_full;
    logic        w_empty;
    logic [7:0]  w_head;
    logic        w_ready;
    logic        w_start;
    logic        w_rx_cond;
    logic        w_tx_cond;
    logic [15:0] w_rdata;
    logic        w_unused;

    assign w_rd = cs & rd;
    assign w_wr = cs & we;

    // The acknowledge cycle masks the receiver's still-asserted ready.
    assign w_intake = rx_ready & ~r_rx_read;
    assign w_pop    = w_rd & (adr == REG_RBUF) & ~w_empty;
    assign w_push   = w_intake & (~w_full | w_pop);

    assign w_ready   = (r_state == TX_IDLE) & ~tx_busy;
    assign w_start   = w_wr & (adr == REG_XBUF) & w_ready;
    assign w_rx_cond = r_rie & ~w_empty;
    assign w_tx_cond = r_xie & w_ready;
    assign w_unused  = ^din[15:8];

    dl11_rx_fifo #(
        .RXDEPTH (RXDEPTH),
        .RXAW    (RXAW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (rx_byte),
        .head  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_comb begin
        w_rdata = '0;
        unique case (adr)
            REG_RCSR: begin
                w_rdata[BIT_DONE] = ~w_empty;
                w_rdata[BIT_IE]   = r_rie;
            end
            REG_RBUF: begin
                if (!w_empty) w_rdata[7:0] = w_head;
                w_rdata[BIT_ERR] = r_ovr;
                w_rdata[BIT_OVR] = r_ovr;
            end
            REG_XCSR: begin
                w_rdata[BIT_DONE] = w_ready;
                w_rdata[BIT_IE]   = r_xie;
            end
            REG_XBUF: w_rdata = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            TX_IDLE:  if (w_start) w_state_nxt = TX_WAITB;
            TX_WAITB: if (tx_busy) w_state_nxt = TX_BUSY;
            TX_BUSY:  if (!tx_busy) w_state_nxt = TX_IDLE;
            default:  w_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= TX_IDLE;
            r_dout    <= '0;
            r_tx_byte <= '0;
            r_rx_read <= 1'b0;
            r_tx_send <= 1'b0;
            r_rie     <= 1'b0;
            r_xie     <= 1'b0;
            r_ovr     <= 1'b0;
            r_rx_cond <= 1'b0;
            r_tx_cond <= 1'b0;
            r_rx_irq  <= 1'b0;
            r_tx_irq  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rx_read <= w_intake;
            r_tx_send <= w_start;
            r_rx_cond <= w_rx_cond;
            r_tx_cond <= w_tx_cond;
            if (w_start) r_tx_byte <= din[7:0];
            if (w_rd) r_dout <= w_rdata;
            if (w_wr && adr == REG_RCSR) r_rie <= din[BIT_IE];
            if (w_wr && adr == REG_XCSR) r_xie <= din[BIT_IE];
            if (w_intake && w_full && !w_pop) r_ovr <= 1'b1;
            else if (w_rd && adr == REG_RBUF) r_ovr <= 1'b0;
            // Acknowledge or a cleared enable beats a same-cycle set.
            if (rx_iak || !r_rie) r_rx_irq <= 1'b0;
            else if (w_rx_cond && !r_rx_cond) r_rx_irq <= 1'b1;
            if (tx_iak || !r_xie) r_tx_irq <= 1'b0;
            else if (w_tx_cond && !r_tx_cond) r_tx_irq <= 1'b1;
        end
    end

    assign dout    = r_dout;
    assign rx_read = r_rx_read;
    assign tx_byte = r_tx_byte;
    assign tx_send = r_tx_send;
    assign rx_irq  = r_rx_irq;
    assign tx_irq  = r_tx_irq;

endmodule

// File: tb/tb_dl11_console.sv
// Directed bench for dl11_console: receive, overrun, transmit,
// interrupt acknowledge, simultaneous push/pop and mid-frame reset.
module tb_dl11_console;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic [1:0]  adr;
    logic        rd;
    logic        we;
    logic [15:0] din;
    logic [15:0] dout;
    logic [7:0]  rx_byte;
    logic        rx_ready;
    logic        rx_read;
    logic [7:0]  tx_byte;
    logic        tx_send;
    logic        tx_busy;
    logic        rx_irq;
    logic        tx_irq;
    logic        rx_iak;
    logic        tx_iak;

    int errors = 0;
    int checks = 0;
    logic [15:0] v;

    dl11_console #(.RXDEPTH(8), .RXAW(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .cs       (cs),
        .adr      (adr),
        .rd       (rd),
        .we       (we),
        .din      (din),
        .dout     (dout),
        .rx_byte  (rx_byte),
        .rx_ready (rx_ready),
        .rx_read  (rx_read),
        .tx_byte  (tx_byte),
        .tx_send  (tx_send),
        .tx_busy  (tx_busy),
        .rx_irq   (rx_irq),
        .tx_irq   (tx_irq),
        .rx_iak   (rx_iak),
        .tx_iak   (tx_iak)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [15:0] val);
        adr = a;
        cs  = 1'b1;
        rd  = 1'b1;
        tick();
        cs  = 1'b0;
        rd  = 1'b0;
        val = dout;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [15:0] d);
        adr = a;
        din = d;
        cs  = 1'b1;
        we  = 1'b1;
        tick();
        cs  = 1'b0;
        we  = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] b);
        int pulses;
        logic seen;
        pulses   = 0;
        seen     = 1'b0;
        rx_byte  = b;
        rx_ready = 1'b1;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (rx_read) begin
                seen = 1'b1;
                pulses++;
            end
        end
        rx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rx_read) pulses++;
        end
        check("rx_read_pulses", 16'(pulses), 16'd1);
    endtask

    initial begin
        reset = 1'b1;
        cs = 1'b0; adr = 2'd0; rd = 1'b0; we = 1'b0; din = '0;
        rx_byte = '0; rx_ready = 1'b0; tx_busy = 1'b0;
        rx_iak = 1'b0; tx_iak = 1'b0;
        tick();
        tick();
        check("rst_dout", dout, 16'h0000);
        check("rst_rx_read", {15'd0, rx_read}, 16'd0);
        check("rst_tx_send", {15'd0, tx_send}, 16'd0);
        check("rst_tx_byte", {8'd0, tx_byte}, 16'h0000);
        check("rst_irqs", {14'd0, rx_irq, tx_irq}, 16'd0);
        reset = 1'b0;
        tick();

        // Receive two bytes
        rx_send(8'h41);
        rx_send(8'h42);
        rd_reg(2'd0, v); check("rx_rcsr_done", v, 16'h0080);
        rd_reg(2'd1, v); check("rx_rbuf_41", v, 16'h0041);
        rd_reg(2'd1, v); check("rx_rbuf_42", v, 16'h0042);
        rd_reg(2'd0, v); check("rx_rcsr_empty", v, 16'h0000);

        // Overrun: nine bytes into eight slots
        for (int i = 0; i < 9; i++) rx_send(8'(i));
        rd_reg(2'd1, v); check("ovr_first", v, 16'hC000);
        for (int i = 1; i < 8; i++) begin
            rd_reg(2'd1, v);
            check("ovr_rest", v, 16'(i));
        end
        rd_reg(2'd0, v); check("ovr_rcsr_empty", v, 16'h0000);

        // Transmit
        wr_reg(2'd2, 16'h0040);
        tick();
        check("tx_irq_ie", {15'd0, tx_irq}, 16'd1);
        rd_reg(2'd2, v); check("tx_xcsr_ready", v, 16'h00C0);
        wr_reg(2'd3, 16'h0155);
        check("tx_send_pulse", {15'd0, tx_send}, 16'd1);
        check("tx_byte_55", {8'd0, tx_byte}, 16'h0055);
        tick();
        check("tx_send_single", {15'd0, tx_send}, 16'd0);
        rd_reg(2'd2, v); check("tx_xcsr_waitb", v, 16'h0040);
        tx_busy = 1'b1;
        tick();
        wr_reg(2'd3, 16'h0066);
        check("tx_busy_nosend", {15'd0, tx_send}, 16'd0);
        tick();
        check("tx_busy_nosend2", {15'd0, tx_send}, 16'd0);
        check("tx_byte_held", {8'd0, tx_byte}, 16'h0055);
        tx_iak = 1'b1;
        tick();
        tx_iak = 1'b0;
        check("tx_iak_clr", {15'd0, tx_irq}, 16'd0);
        tx_busy = 1'b0;
        tick();
        tick();
        check("tx_irq_again", {15'd0, tx_irq}, 16'd1);
        rd_reg(2'd2, v); check("tx_xcsr_idle", v, 16'h00C0);
        wr_reg(2'd2, 16'h0000);
        tick();
        check("tx_ie_clr", {15'd0, tx_irq}, 16'd0);

        // Receive interrupt acknowledge
        wr_reg(2'd0, 16'h0040);
        rx_send(8'h11);
        check("rx_irq_set", {15'd0, rx_irq}, 16'd1);
        rx_iak = 1'b1;
        tick();
        rx_iak = 1'b0;
        check("rx_iak_clr", {15'd0, rx_irq}, 16'd0);
        rd_reg(2'd0, v); check("rx_done_stays", v, 16'h00C0);
        check("rx_irq_stays0", {15'd0, rx_irq}, 16'd0);
        rd_reg(2'd1, v); check("rx_rbuf_11", v, 16'h0011);
        rx_send(8'h12);
        check("rx_irq_reset", {15'd0, rx_irq}, 16'd1);
        rd_reg(2'd1, v); check("rx_rbuf_12", v, 16'h0012);

        // Simultaneous push and pop while full
        for (int i = 0; i < 8; i++) rx_send(8'(8'hA0 + i));
        rx_iak = 1'b1;
        tick();
        rx_iak = 1'b0;
        check("sim_iak", {15'd0, rx_irq}, 16'd0);
        rx_byte  = 8'hA8;
        rx_ready = 1'b1;
        adr = 2'd1; cs = 1'b1; rd = 1'b1;
        tick();
        cs = 1'b0; rd = 1'b0; rx_ready = 1'b0;
        check("sim_pop_a0", dout, 16'h00A0);
        check("sim_rx_read", {15'd0, rx_read}, 16'd1);
        for (int i = 1; i < 9; i++) begin
            rd_reg(2'd1, v);
            check("sim_drain", v, 16'(16'h00A0 + i));
        end
        rd_reg(2'd0, v); check("sim_rcsr_empty", v, 16'h0040);
        rx_byte  = 8'h33;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        rx_iak   = 1'b1;
        tick();
        rx_iak   = 1'b0;
        check("sim_iak_wins", {15'd0, rx_irq}, 16'd0);
        tick();
        check("sim_iak_wins2", {15'd0, rx_irq}, 16'd0);

        // Reset during BUSY with three bytes queued
        rx_send(8'h34);
        rx_send(8'h35);
        wr_reg(2'd2, 16'h0040);
        wr_reg(2'd3, 16'h0077);
        tx_busy = 1'b1;
        tick();
        tick();
        check("pre_rst_tx_irq", {15'd0, tx_irq}, 16'd1);
        check("pre_rst_tx_byte", {8'd0, tx_byte}, 16'h0077);
        rd_reg(2'd0, v); check("pre_rst_rcsr", v, 16'h00C0);
        reset = 1'b1;
        #1;
        check("mid_rst_dout", dout, 16'h0000);
        check("mid_rst_tx_byte", {8'd0, tx_byte}, 16'h0000);
        check("mid_rst_pulses", {14'd0, rx_read, tx_send}, 16'd0);
        check("mid_rst_irqs", {14'd0, rx_irq, tx_irq}, 16'd0);
        tick();
        reset = 1'b0;
        rd_reg(2'd0, v); check("post_rst_rcsr", v, 16'h0000);
        rd_reg(2'd2, v); check("post_rst_xcsr_busy", v, 16'h0000);
        rd_reg(2'd1, v); check("post_rst_rbuf", v, 16'h0000);
        tx_busy = 1'b0;
        rd_reg(2'd2, v); check("post_rst_xcsr_ready", v, 16'h0080);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dl11_console.md
Name: dl11_console

Overview:
- CPU-side end of the console serial link: a DL11-style register file on the PDP-11 bus that consumes the byte handshake of the UART receiver (rxbyte/ready/rxread) and drives the byte handshake of the UART transmitter (sbyte/send/busy).
- Buffers received bytes in a small FIFO, tracks transmit progress with a state machine, and raises separate receive and transmit interrupt requests.
- Sits between the bus decoder and the 38400-baud serial_rx/serial_tx pair.

Parameters:
- RXDEPTH, 8: RX FIFO depth in bytes; must be a power of 2, minimum 2.
- RXAW, 3: log2(RXDEPTH), the FIFO pointer width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cs  in  1  register block selected for this cycle.
- adr  in  2  word select: 0=RCSR(177560) 1=RBUF(177562) 2=XCSR(177564) 3=XBUF(177566).
- rd  in  1  read strobe, one cycle, qualified by cs.
- we  in  1  write strobe, one cycle, qualified by cs; only the low byte is used.
- din  in  16  write data.
- dout  out  16  read data, registered.
- rx_byte  in  8  receiver data.
- rx_ready  in  1  receiver byte available.
- rx_read  out  1  receiver acknowledge, registered one-cycle pulse.
- tx_byte  out  8  transmitter data, held stable while sending.
- tx_send  out  1  transmitter start, registered one-cycle pulse.
- tx_busy  in  1  transmitter busy.
- rx_irq  out  1  receive interrupt request.
- tx_irq  out  1  transmit interrupt request.
- rx_iak  in  1  receive interrupt acknowledge, one cycle.
- tx_iak  in  1  transmit interrupt acknowledge, one cycle.

Behaviour:
- Reset values: dout=0, rx_read=0, tx_send=0, tx_byte=0, rx_irq=0, tx_irq=0. Reset also clears the FIFO, RIE, XIE and OVR, and puts the TX FSM in IDLE. Reset mid-frame abandons the frame; a byte in flight in serial_tx is not tracked.
- Register map:
  - RCSR: bit7 DONE = FIFO not empty (read-only); bit6 RIE (read/write); all other bits 0.
  - RBUF: bits 7:0 FIFO head (0 if empty); bit15 ERR = OVR; bit14 OVR; other bits 0.
  - XCSR: bit7 READY (read-only); bit6 XIE (read/write); all other bits 0.
  - XBUF: reads 0; a write of bits 7:0 starts transmission.
- Reads: dout is updated at the edge where cs&rd=1 and valid the next cycle; in all other cycles dout holds. A read of RBUF pops the FIFO at that same edge (only if non-empty) and clears OVR after dout captures it.
- RX intake:
  - At an edge with rx_ready=1 and rx_read=0, push rx_byte and set rx_read=1 for exactly one cycle.
  - rx_read=1 blocks a second push, covering the cycle in which the receiver still shows ready.
  - FIFO full at intake: drop the byte, set OVR, still pulse rx_read.
  - Simultaneous push and pop: both take effect, including when full (count unchanged, no overrun) and when empty with push only.
- TX FSM:
  - IDLE: READY = !tx_busy. A write to XBUF with READY=1 latches tx_byte=din[7:0], pulses tx_send for one cycle, and goes to WAITB. A write with READY=0 is ignored.
  - WAITB: wait for tx_busy=1 (serial_tx asserts it 2 cycles after send), then go to BUSY.
  - BUSY: wait for tx_busy=0, then go to IDLE.
  - READY=0 in WAITB and BUSY.
- Interrupts: each request is a latch.
  - rx_irq is set on a 0->1 edge of (RIE & DONE); tx_irq on a 0->1 edge of (XIE & READY). Setting IE while its flag is already 1 counts as an edge.
  - Each latch is cleared by its own iak, by clearing its IE bit, or by reset.
  - Set and iak in the same cycle: iak wins.
  - The two channels are independent; vector selection belongs to the bus arbiter.
- Width rules: FIFO pointers are RXAW+1 bits and wrap naturally; full/empty are derived from the pointer MSB comparison.

Decomposition:
- Package dl11_pkg holds:
  - register offsets RCSR/RBUF/XCSR/XBUF;
  - bit positions DONE=7, IE=6, ERR=15, OVR=14;
  - vectors RX_VEC=8'o60, TX_VEC=8'o64;
  - TX FSM state encoding IDLE/WAITB/BUSY.
- One sub-module, dl11_rx_fifo: synchronous FIFO with push, pop, head, full and empty outputs, parameterised by RXDEPTH/RXAW.

Test Plan:
- Receive: drive rx_ready with bytes 0x41 then 0x42, holding ready until rx_read is seen. Expect exactly one rx_read pulse per byte and RCSR=0x0080. RBUF reads return 0x0041 then 0x0042, after which RCSR=0x0000.
- Overrun: push 9 bytes (0x00..0x08) with no reads and RXDEPTH=8. Expect 8 bytes stored and the 9th dropped. The first RBUF read returns 0xC000, with OVR cleared afterwards; subsequent reads return 0x01..0x07.
- Transmit: write XCSR=0x0040 and expect tx_irq to rise. Write XBUF=0x0155 and expect tx_byte=0x55, a single tx_send pulse, and READY=0. A second XBUF write of 0x0066 during BUSY produces no tx_send. After tx_busy falls, READY=1 and tx_irq re-asserts once tx_iak has been given.
- Interrupt ack: set RIE, receive one byte, and expect rx_irq=1. Pulse rx_iak and expect rx_irq=0 while DONE stays 1. Read RBUF and receive a new byte, and expect rx_irq=1 again.
- Simultaneous: with the FIFO full, a push and an RBUF pop on the same edge give no OVR and an unchanged count. Rx_iak coinciding with an rx_irq set edge leaves rx_irq=0.
- Reset mid-op: assert reset during BUSY with 3 bytes queued. Immediately expect all outputs 0, RCSR=0 and XCSR.IE=0. After release, XCSR READY follows tx_busy.
